// File: rtl/frame_cmd_scheduler_if.sv
// Command-side bus of the frame command scheduler.
// Avalon-style write strobe/data plus FIFO status flags.
interface fcs_if;
  logic        cmd_write;
  logic [31:0] cmd_writedata;
  logic        fifo_full;
  logic        overflow;

  modport master (
    output cmd_write,
    output cmd_writedata,
    input  fifo_full,
    input  overflow
  );

  modport slave (
    input  cmd_write,
    input  cmd_writedata,
    output fifo_full,
    output overflow
  );
endinterface

// File: rtl/frame_cmd_scheduler.sv
// Frame command scheduler: FIFO replay of sprite commands, vblank-held swap.
// Optional macro FCS_IRQ_EN adds a sticky swap interrupt cleared by ack words.
module frame_cmd_scheduler #(
  parameter int FIFO_DEPTH  = 16,
  parameter int VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  fcs_if.slave        bus,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] writedata_out,
  output logic        front_buf,
  output logic        swap_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0] VB_LINE = 10'(VBLANK_LINE);
  localparam logic [3:0] INFO_WR = 4'b0001;
  localparam logic [3:0] INFO_CM = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_VB,
    SWAP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   wd_q, wd_d;
  logic          front_q, front_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    info_in;
  logic          keep;
  logic          full;
  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic          vblank;

  // Enqueue filter, full check and head-of-queue view.
  always_comb begin
    info_in = bus.cmd_writedata[20:17];
    keep    = bus.cmd_write &&
              (info_in == INFO_WR || info_in == INFO_CM);
    full    = (count_q == DEPTH_C);
    push    = keep && !full;
    head    = mem_q[rd_ptr_q];
    vblank  = (vcount == VB_LINE) && (hcount == 10'd0);
  end

  // Next state, pointer/count update and the registered output word.
  always_comb begin
    state_d  = state_q;
    wd_d     = 32'h0;
    front_d  = front_q;
    ovf_d    = ovf_q | (keep && full);
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        pop = 1'b1;
      end
      WAIT_VB: begin
        if (vblank) state_d = SWAP;
      end
      SWAP: begin
        wd_d    = {11'b0, INFO_CM, 3'b0, ~front_q, 13'b0};
        front_d = ~front_q;
        state_d = (count_q != '0) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    if (pop) begin
      if (head[20:17] == INFO_CM) begin
        state_d = WAIT_VB;
      end else begin
        wd_d    = {head[31:14], ~front_q, head[12:0]};
        state_d = (count_d == '0) ? IDLE : ISSUE;
      end
    end
  end

  // Command storage; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.cmd_writedata;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wd_q     <= 32'h0;
      front_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wd_q     <= wd_d;
      front_q  <= front_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef FCS_IRQ_EN
  logic irq_q, irq_d;
  logic irq_set, irq_ack;

  // Sticky interrupt: set by the swap, cleared by an ack word; set wins.
  always_comb begin
    irq_set = (state_q == SWAP);
    irq_ack = bus.cmd_write && (info_in == 4'b0010);
    irq_d   = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  // Interrupt register.
  always_ff @(posedge clk) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign swap_irq = irq_q;
`else
  assign swap_irq = 1'b0;
`endif

  assign writedata_out = wd_q;
  assign front_buf     = front_q;
  assign bus.fifo_full = full;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Scoreboard bench for frame_cmd_scheduler: queue-based reference model,
// per-cycle expected outputs pushed at posedge, compared at negedge.
module tb_frame_cmd_scheduler;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [31:0] writedata_out;
  logic        front_buf;
  logic        swap_irq;

  fcs_if bus();

  frame_cmd_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .VBLANK_LINE(480)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .hcount       (hcount),
    .vcount       (vcount),
    .writedata_out(writedata_out),
    .front_buf    (front_buf),
    .swap_irq     (swap_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic        front;
    logic        full;
    logic        ovf;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   flush_seen = 0;
  int   words_seen = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Reference model: the pending work is a plain queue of words; the
  // replayer is either resting, replaying, holding a commit for vblank,
  // or flipping buffers. Each edge it produces the next visible word.
  localparam int REST = 0, REPLAY = 1, HOLD = 2, FLIP = 3;
  logic [31:0] mq[$];
  int          mode = REST;
  bit          m_front = 0, m_ovf = 0, m_irq = 0, armed = 0;
  int          n0;
  logic [31:0] w, out_n;
  logic [3:0]  inf;
  bit          keep, did_data, set_irq;
  exp_t        ex;

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      mq.delete();
      mode = REST;
      m_front = 0;
      m_ovf = 0;
      m_irq = 0;
      armed = 1;
      ex.out = 32'h0;
      ex.front = 0;
      ex.full = 0;
      ex.ovf = 0;
      ex.irq = 0;
      exp_q.push_back(ex);
    end else if (armed) begin
      n0 = mq.size();
      out_n = 32'h0;
      inf = bus.cmd_writedata[20:17];
      keep = bus.cmd_write && (inf == 4'b0001 || inf == 4'b1111);
      did_data = 0;
      set_irq = 0;
      case (mode)
        REST: if (n0 > 0) mode = REPLAY;
        REPLAY: begin
          w = mq.pop_front();
          if (w[20:17] == 4'b1111) mode = HOLD;
          else begin
            out_n = w;
            out_n[13] = !m_front;
            did_data = 1;
          end
        end
        HOLD: if (vcount == 10'd480 && hcount == 10'd0) mode = FLIP;
        default: begin
          out_n = 32'h001E0000;
          out_n[13] = !m_front;
          m_front = !m_front;
          set_irq = 1;
          mode = (n0 > 0) ? REPLAY : REST;
        end
      endcase
      if (keep) begin
        if (n0 == DEPTH) m_ovf = 1;
        else mq.push_back(bus.cmd_writedata);
      end
      if (did_data && mq.size() == 0) mode = REST;
`ifdef FCS_IRQ_EN
      if (set_irq) m_irq = 1;
      else if (bus.cmd_write && inf == 4'b0010) m_irq = 0;
`endif
      ex.out = out_n;
      ex.front = m_front;
      ex.full = (mq.size() == DEPTH);
      ex.ovf = m_ovf;
      ex.irq = m_irq;
      exp_q.push_back(ex);
    end
  end

  // Monitor: compares every presented output cycle against the model.
  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out", writedata_out, e.out);
      chk("front_buf", 32'(front_buf), 32'(e.front));
      chk("fifo_full", 32'(bus.fifo_full), 32'(e.full));
      chk("overflow", 32'(bus.overflow), 32'(e.ovf));
      chk("swap_irq", 32'(swap_irq), 32'(e.irq));
      if (writedata_out == 32'h001E2000) flush_seen++;
      if (writedata_out[20:17] == 4'b0001) words_seen++;
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] i, input bit pp);
    logic [31:0] r;
    r = $urandom;
    r[20:17] = i;
    r[13] = pp;
    return r;
  endfunction

  task automatic step(input bit wr, input logic [31:0] d,
                      input bit vb, input bit rn);
    bus.cmd_write = wr;
    bus.cmd_writedata = wr ? d : $urandom;
    reset = rn;
    if (vb) begin
      vcount = 10'd480;
      hcount = 10'd0;
    end else begin
      case ($urandom_range(0, 3))
        0: {vcount, hcount} = {10'd480, 10'd1};
        1: {vcount, hcount} = {10'd479, 10'd0};
        default: begin
          vcount = 10'($urandom_range(0, 524));
          hcount = 10'($urandom_range(1, 799));
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 1);
  endtask

  int w0, f0;
  logic [3:0] ri;

  initial begin
    reset = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_writedata = 32'h0;
    hcount = 10'd5;
    vcount = 10'd5;
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0);

    w0 = words_seen;
    for (int i = 0; i < 3; i++) step(1, mk(4'b0001, 0), 0, 1);
    idle(6);
    chk("s1_words", 32'(words_seen - w0), 32'd3);

    f0 = flush_seen;
    step(1, mk(4'b0001, 0), 0, 1);
    step(1, mk(4'b0001, 0), 0, 1);
    step(1, mk(4'b1111, 0), 0, 1);
    step(1, mk(4'b0001, 0), 0, 1);
    idle(10);
    step(0, 32'h0, 1, 1);
    idle(8);
    chk("s2_flush", 32'(flush_seen - f0), 32'd1);
    chk("s2_front", 32'(front_buf), 32'd1);

    step(1, mk(4'b1111, 0), 0, 1);
    idle(4);
    for (int i = 0; i < 17; i++) step(1, mk(4'b0001, 1), 0, 1);
    chk("s3_full", 32'(bus.fifo_full), 32'd1);
    chk("s3_ovf", 32'(bus.overflow), 32'd1);
    w0 = words_seen;
    step(0, 32'h0, 1, 1);
    idle(25);
    chk("s3_words", 32'(words_seen - w0), 32'd16);

    step(1, mk(4'b0101, 0), 0, 1);
    step(1, mk(4'b0000, 0), 0, 1);
    idle(5);

    step(1, mk(4'b1111, 0), 0, 1);
    idle(4);
    for (int i = 0; i < 5; i++) step(1, mk(4'b0001, 0), 0, 1);
    step(0, 32'h0, 0, 0);
    chk("s5_front", 32'(front_buf), 32'd0);
    step(0, 32'h0, 1, 1);
    idle(8);

    step(1, mk(4'b1111, 0), 0, 1);
    idle(4);
    step(0, 32'h0, 1, 1);
    step(1, mk(4'b0010, 0), 0, 1);
    idle(3);
    step(1, mk(4'b0010, 0), 0, 1);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ri = 4'b0001;
        6: ri = 4'b1111;
        7: ri = 4'b0010;
        8: ri = 4'b0000;
        default: ri = 4'b0101;
      endcase
      step($urandom_range(0, 9) < 6, mk(ri, 1'($urandom)),
           $urandom_range(0, 29) == 0, $urandom_range(0, 399) != 0);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
